// File: rtl/icache_miss_ctrl.sv
// rtl/icache_miss_ctrl.sv - instruction cache miss controller
// Stalls fetch on a miss, fetches one block from DRAM, fills the cache and replays the lookup.
`timescale 1ns/1ps
module icache_miss_ctrl #(
   parameter int ADDR_WIDTH      = 32,
   parameter int BLOCK_SIZE_BITS = 64,
   parameter int OFFSET_BITS     = 3
) (
   input  logic                       clk,
   input  logic                       rst_aL,
   input  logic                       fetch_req_valid,
   input  logic [ADDR_WIDTH-1:0]      fetch_addr,
   input  logic                       flush,
   output logic                       fetch_stall,
   output logic                       fetch_data_valid,
   output logic [ADDR_WIDTH-1:0]      cache_addr,
   input  logic                       cache_hit,
   output logic                       cache_we_aL,
   output logic [BLOCK_SIZE_BITS-1:0] cache_write_data,
   output logic                       dram_req_valid,
   input  logic                       dram_req_ready,
   output logic [ADDR_WIDTH-1:0]      dram_req_addr,
   input  logic                       dram_resp_valid,
   input  logic [BLOCK_SIZE_BITS-1:0] dram_resp_data,
   output logic [31:0]                miss_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_FILL, S_REPLAY, S_DRAIN
   } state_t;

   state_t                     state_q;
   logic [ADDR_WIDTH-1:0]      miss_addr_q;
   logic [BLOCK_SIZE_BITS-1:0] fill_q;
   logic [31:0]                miss_count_q;
   logic [31:0]                miss_count_d;

   assign miss_count_d = (miss_count_q == 32'hFFFF_FFFF) ? miss_count_q : miss_count_q + 32'd1;

   always_ff @(posedge clk) begin
      if (!rst_aL) begin
         state_q      <= S_IDLE;
         miss_addr_q  <= '0;
         fill_q       <= '0;
         miss_count_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (fetch_req_valid && !cache_hit && !flush) begin
                  miss_addr_q <= fetch_addr;
                  state_q     <= S_REQ;
               end
            end
            S_REQ: begin
               // An accepted request must be drained even if flushed in the same cycle.
               if (dram_req_ready) begin
                  miss_count_q <= miss_count_d;
                  state_q      <= flush ? S_DRAIN : S_WAIT;
               end else if (flush) begin
                  state_q <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (dram_resp_valid) begin
                  if (flush) begin
                     state_q <= S_IDLE;
                  end else begin
                     fill_q  <= dram_resp_data;
                     state_q <= S_FILL;
                  end
               end else if (flush) begin
                  state_q <= S_DRAIN;
               end
            end
            S_FILL:   state_q <= flush ? S_IDLE : S_REPLAY;
            S_REPLAY: state_q <= (flush || cache_hit) ? S_IDLE : S_REQ;
            S_DRAIN: begin
               if (dram_resp_valid) state_q <= S_IDLE;
            end
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      cache_addr       = miss_addr_q;
      fetch_stall      = 1'b1;
      fetch_data_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            cache_addr       = fetch_addr;
            fetch_stall      = fetch_req_valid && !cache_hit && !flush;
            fetch_data_valid = fetch_req_valid && cache_hit && !flush;
         end
         S_REPLAY: fetch_data_valid = cache_hit && !flush;
         default: ;
      endcase
   end

   assign cache_we_aL      = (state_q != S_FILL);
   assign cache_write_data = fill_q;
   assign dram_req_valid   = (state_q == S_REQ);
   assign dram_req_addr    = {miss_addr_q[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   assign miss_count       = miss_count_q;

endmodule

// File: doc/icache_miss_ctrl.md
ICACHE_MISS_CTRL -- requirements
Module: icache_miss_ctrl

Interface
REQ-001 Parameters: ADDR_WIDTH, 32, address width; BLOCK_SIZE_BITS, 64, icache block / DRAM beat width; OFFSET_BITS, 3, byte-offset bits in a block.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_aL  input  1  reset, synchronous, active-low.
REQ-004 fetch_req_valid  input  1  fetch stage presents fetch_addr this cycle.
REQ-005 fetch_addr  input  ADDR_WIDTH  fetch byte address.
REQ-006 flush  input  1  redirect; abandon any outstanding miss.
REQ-007 fetch_stall  output  1  fetch must hold / re-present its request.
REQ-008 fetch_data_valid  output  1  cache selected_data_way is valid for fetch this cycle.
REQ-009 cache_addr  output  ADDR_WIDTH  address driven to icache.
REQ-010 cache_hit  input  1  icache hit for cache_addr (combinational).
REQ-011 cache_we_aL  output  1  icache write enable, active-low.
REQ-012 cache_write_data  output  BLOCK_SIZE_BITS  fill data to icache.
REQ-013 dram_req_valid / dram_req_ready  output / input  1 / 1  DRAM request handshake.
REQ-014 dram_req_addr  output  ADDR_WIDTH  block-aligned miss address (low OFFSET_BITS zero).
REQ-015 dram_resp_valid / dram_resp_data  input / input  1 / BLOCK_SIZE_BITS  DRAM fill response, no backpressure.
REQ-016 miss_count  output  32  saturating count of accepted DRAM requests.

Function
REQ-017 States IDLE, REQ, WAIT, FILL, REPLAY, DRAIN; one-hot or encoded, implementer's choice.
REQ-018 IDLE: cache_addr=fetch_addr; fetch_data_valid=fetch_req_valid&cache_hit; on fetch_req_valid&!cache_hit&!flush latch miss_addr=fetch_addr, assert fetch_stall same cycle, go REQ.
REQ-019 REQ: dram_req_valid=1, dram_req_addr=miss_addr with low OFFSET_BITS cleared, held stable until dram_req_ready; on handshake increment miss_count (saturate at 2^32-1), go WAIT.
REQ-020 WAIT: on dram_resp_valid capture dram_resp_data into fill register, go FILL; dram_resp_valid ignored in IDLE, REQ, FILL, REPLAY.
REQ-021 FILL: exactly one cycle, cache_addr=miss_addr, cache_we_aL=0, cache_write_data=fill register; go REPLAY.
REQ-022 REPLAY: cache_addr=miss_addr, cache_we_aL=1; if cache_hit assert fetch_data_valid, go IDLE; else go REQ (re-miss, counted again).
REQ-023 fetch_stall=1 in every state except IDLE; fetch_data_valid=0 in REQ, WAIT, FILL, DRAIN.
REQ-024 Minimum miss latency: miss detected cycle N, ready=1 at N+1, response at N+2 -> FILL N+3, data valid N+4.
REQ-025 flush in IDLE: no miss latched, fetch_data_valid=0. In REQ before/at handshake: if handshake occurs same cycle go DRAIN, else drop request, go IDLE. In WAIT: go DRAIN (or IDLE if dram_resp_valid same cycle, data discarded, no fill). In FILL: write completes, go IDLE. In REPLAY: go IDLE, fetch_data_valid=0.
REQ-026 DRAIN: wait for dram_resp_valid, discard data, no cache write, go IDLE; further flush ignored.
REQ-027 cache_we_aL=0 only in FILL; never two consecutive cycles.

Reset
REQ-028 rst_aL=0 at a clock edge forces IDLE from any state, clears miss_count, fill register, miss_addr.
REQ-029 Outputs during/after reset: dram_req_valid=0, cache_we_aL=1, fetch_stall=0, fetch_data_valid=0, miss_count=0; an in-flight DRAM response after reset is ignored.

Verification
REQ-030 Hit: IDLE, fetch_addr=0x0000_0004, cache_hit=1 -> fetch_data_valid=1, fetch_stall=0, no dram_req_valid.
REQ-031 Miss/fill: addr 0x0000_0044 miss, ready=1, resp data 0x7654_3210 -> dram_req_addr=0x0000_0040, one cycle cache_we_aL=0 with that data, REPLAY hit -> fetch_data_valid, miss_count=1.
REQ-032 Backpressure: dram_req_ready low 5 cycles -> dram_req_valid and addr stable 5 cycles, miss_count increments once.
REQ-033 Flush in WAIT: flush then resp 3 cycles later -> DRAIN, no cache_we_aL=0, returns IDLE after resp, fetch_stall drops.
REQ-034 Replay re-miss: cache_hit=0 in REPLAY -> second DRAM request same address, miss_count=2.
REQ-035 Reset in WAIT: rst_aL=0 one cycle then late resp -> IDLE, outputs at reset values, response ignored, miss_count=0.
